mic_i2s_capture: RTL

- Front-end stage feeding the recorder core with microphone samples.
- Deserialises the I2S microphone stream (BCLK, LRCK, serial data) in the system clock domain, selects one channel, and buffers 16-bit words in a small FIFO.
- Presents buffered words to the downstream SRAM writer over a valid/ready handshake.
- Gated by start/stop pulses from the top-level control.

---
 rtl/mic_i2s_capture_if.sv | 13 +
 rtl/mic_i2s_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mic_i2s_capture_if.sv
// Downstream word handshake of mic_i2s_capture: FIFO head word, its channel tag,
// and valid/ready flow control towards the SRAM writer.
interface mic_i2s_capture_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_chan;

  modport master (output o_data, output o_valid, output o_chan, input i_ready);
  modport slave  (input o_data, input o_valid, input o_chan, output i_ready);
endinterface

// File: rtl/mic_i2s_capture.sv
// I2S microphone capture: synchronises BCLK/LRCK/DAT, deserialises one channel
// (both when MIC_STEREO_EN is defined) and buffers words in a small FIFO.
module mic_i2s_capture #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CHANNEL     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_BCLK,
  input  logic                  i_LRCK,
  input  logic                  i_DAT,
  mic_i2s_capture_if.master     bus,
  output logic                  o_busy,
  output logic                  o_overflow,
  output logic [15:0]           o_sample_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_W + 1);

`ifdef MIC_STEREO_EN
  typedef struct packed {
    logic              chan;
    logic [DATA_W-1:0] data;
  } entry_t;
`else
  localparam logic CHAN_BIT = (CHANNEL != 0);
  typedef struct packed {
    logic [DATA_W-1:0] data;
  } entry_t;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q,  dat_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lr_prev_q,   lr_prev_d;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
`ifdef MIC_STEREO_EN
  logic                   cur_chan_q, cur_chan_d;
`endif

  entry_t                 mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_q, valid_d;
  entry_t                 head_q, head_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            sample_cnt_q, sample_cnt_d;

  logic                   bclk_s, lrck_s, dat_s;
  logic                   bclk_rise, lr_edge, lane_ok, frame_start;
  logic [DATA_W-1:0]      shifted_word;
  logic                   push, accept, pop, full;
  entry_t                 push_entry;

  assign bclk_s       = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s       = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s        = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise    = bclk_s & ~bclk_prev_q;
  assign lr_edge      = bclk_rise && (lrck_s != lr_prev_q);
`ifdef MIC_STEREO_EN
  assign lane_ok      = 1'b1;
`else
  assign lane_ok      = (lrck_s == CHAN_BIT);
`endif
  assign frame_start  = lr_edge && lane_ok;
  assign shifted_word = {shift_q[DATA_W-2:0], dat_s};
  assign pop          = valid_q && bus.i_ready;
  assign full         = (count_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], i_BCLK};
    lrck_sync_d  = {lrck_sync_q[SYNC_STAGES-2:0], i_LRCK};
    dat_sync_d   = {dat_sync_q[SYNC_STAGES-2:0],  i_DAT};
    bclk_prev_d  = bclk_s;
    lr_prev_d    = bclk_rise ? lrck_s : lr_prev_q;
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
`ifdef MIC_STEREO_EN
    cur_chan_d   = cur_chan_q;
`endif
    push         = 1'b0;
    accept       = 1'b0;
    push_entry   = '0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    valid_d      = valid_q;
    head_d       = head_q;
    overflow_d   = overflow_q;
    sample_cnt_d = sample_cnt_q;

    if (i_start) begin
      state_d   = WAIT_FRAME;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (i_stop) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (bclk_rise) begin
      case (state_q)
        WAIT_FRAME: if (frame_start) begin
          state_d   = SHIFT;
          shift_d   = '0;
          bit_cnt_d = '0;
`ifdef MIC_STEREO_EN
          cur_chan_d = lrck_s;
`endif
        end
        SHIFT: if (lr_edge) begin
          // Slot ended early: drop the partial word and treat this rise as a frame edge.
          state_d   = frame_start ? SHIFT : WAIT_FRAME;
          shift_d   = '0;
          bit_cnt_d = '0;
`ifdef MIC_STEREO_EN
          cur_chan_d = lrck_s;
`endif
        end else begin
          shift_d   = shifted_word;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            push    = 1'b1;
            state_d = WAIT_FRAME;
          end
        end
        default: ;
      endcase
    end

    push_entry.data = shifted_word;
`ifdef MIC_STEREO_EN
    push_entry.chan = cur_chan_q;
`endif

    if (i_start) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      valid_d      = 1'b0;
      overflow_d   = 1'b0;
      sample_cnt_d = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) begin
        if (!full || pop) begin
          accept       = 1'b1;
          wr_ptr_d     = wr_ptr_q + PTR_W'(1);
          sample_cnt_d = sample_cnt_q + 16'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end
      case ({accept, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: ;
      endcase
      valid_d = (count_d != '0);
      // Registered head: bypass the pushed word when it lands in an otherwise empty FIFO.
      if (count_d != '0) head_d = (accept && count_d == CNT_W'(1)) ? push_entry : mem_q[rd_ptr_d];
    end
  end

  // NOTE: the FIFO storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge i_clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_entry;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      dat_sync_q   <= '0;
      bclk_prev_q  <= 1'b0;
      lr_prev_q    <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
`ifdef MIC_STEREO_EN
      cur_chan_q   <= 1'b0;
`endif
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      head_q       <= '0;
      overflow_q   <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      bclk_sync_q  <= bclk_sync_d;
      lrck_sync_q  <= lrck_sync_d;
      dat_sync_q   <= dat_sync_d;
      bclk_prev_q  <= bclk_prev_d;
      lr_prev_q    <= lr_prev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
`ifdef MIC_STEREO_EN
      cur_chan_q   <= cur_chan_d;
`endif
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      head_q       <= head_d;
      overflow_q   <= overflow_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_data    = head_q.data;
`ifdef MIC_STEREO_EN
  assign bus.o_chan    = head_q.chan;
`else
  assign bus.o_chan    = CHAN_BIT;
`endif
  assign o_busy        = (state_q != IDLE);
  assign o_overflow    = overflow_q;
  assign o_sample_cnt  = sample_cnt_q;

endmodule
